// File: rtl/scan_disp_ctrl.sv
// scan_disp_ctrl
//   Captures an 8-bit binary value, converts it to BCD with a
//   bit-serial double-dabble (8 cycles), commits the digits and
//   drives a multiplexed 3-digit common-anode 7-segment display.
//   Leading zeros on hundreds/tens are blanked.
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   in     : 8-bit value to display
//   load   : capture request (ignored while busy)
//   busy   : conversion/commit in progress (registered)
//   done   : one-cycle pulse during the commit cycle
//   seg    : segments, active-low, seg[0]=a .. seg[6]=g
//   sel    : digit select, active-low one-cold (0=ones,1=tens,2=hundreds)
module scan_disp_ctrl #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in,
    input  logic       load,
    output logic       busy,
    output logic       done,
    output logic [6:0] seg,
    output logic [2:0] sel
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SCAN_MAX = CW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
    typedef enum logic [1:0] {DIG_ONES, DIG_TENS, DIG_HUNS} dig_t;

    state_t state, nxt;

    logic [7:0] sh;
    logic [9:0] bcd;
    logic [9:0] bcd_step;
    logic [3:0] adj_ones, adj_tens;
    logic [2:0] bitcnt;

    logic [1:0] d_huns;
    logic [3:0] d_tens, d_ones;

    logic [CW-1:0] scan_cnt;
    dig_t          idx;

    logic [3:0] val;
    logic       blank;
    logic [6:0] seg_nx;
    logic [2:0] sel_nx;

    // ---------------- FSM ----------------
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (load) nxt = CONV;
            CONV:    if (bitcnt == 3'd7) nxt = COMMIT;
            COMMIT:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // One double-dabble step: adjust ones/tens nibbles, then shift in the
    // next input bit. Hundreds is at most 1 before the last shift, so it
    // never needs an adjust.
    always_comb begin
        adj_ones = bcd[3:0];
        adj_tens = bcd[7:4];
        if (bcd[3:0] >= 4'd5) adj_ones = bcd[3:0] + 4'd3;
        if (bcd[7:4] >= 4'd5) adj_tens = bcd[7:4] + 4'd3;
        bcd_step = {bcd[8], adj_tens, adj_ones, sh[7]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            sh     <= '0;
            bcd    <= '0;
            bitcnt <= '0;
            d_huns <= '0;
            d_tens <= '0;
            d_ones <= '0;
        end else begin
            state <= nxt;
            busy  <= (nxt != IDLE);
            done  <= (nxt == COMMIT);
            case (state)
                IDLE: begin
                    if (load) begin
                        sh     <= in;
                        bcd    <= '0;
                        bitcnt <= '0;
                    end
                end
                CONV: begin
                    sh     <= {sh[6:0], 1'b0};
                    bcd    <= bcd_step;
                    bitcnt <= bitcnt + 3'd1;
                end
                COMMIT: begin
                    d_huns <= bcd[9:8];
                    d_tens <= bcd[7:4];
                    d_ones <= bcd[3:0];
                end
                default: ;
            endcase
        end
    end

    // ---------------- Scan ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= DIG_ONES;
        end else if (scan_cnt == SCAN_MAX) begin
            scan_cnt <= '0;
            case (idx)
                DIG_ONES: idx <= DIG_TENS;
                DIG_TENS: idx <= DIG_HUNS;
                default:  idx <= DIG_ONES;
            endcase
        end else begin
            scan_cnt <= scan_cnt + CW'(1);
        end
    end

    always_comb begin
        val    = d_ones;
        blank  = 1'b0;
        sel_nx = 3'b110;
        case (idx)
            DIG_TENS: begin
                val    = d_tens;
                blank  = (d_huns == 2'd0) && (d_tens == 4'd0);
                sel_nx = 3'b101;
            end
            DIG_HUNS: begin
                val    = {2'b00, d_huns};
                blank  = (d_huns == 2'd0);
                sel_nx = 3'b011;
            end
            default: ;
        endcase

        case (val)
            4'd0:    seg_nx = 7'b1000000;
            4'd1:    seg_nx = 7'b1111001;
            4'd2:    seg_nx = 7'b0100100;
            4'd3:    seg_nx = 7'b0110000;
            4'd4:    seg_nx = 7'b0011001;
            4'd5:    seg_nx = 7'b0010010;
            4'd6:    seg_nx = 7'b0000010;
            4'd7:    seg_nx = 7'b1111000;
            4'd8:    seg_nx = 7'b0000000;
            4'd9:    seg_nx = 7'b0011000;
            default: seg_nx = 7'b1111111;
        endcase
        if (blank) seg_nx = '1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg <= '1;
            sel <= '1;
        end else begin
            seg <= seg_nx;
            sel <= sel_nx;
        end
    end

endmodule
